ser_mem_cmd: RTL and testbench

- Serial-port command engine that drives the second (serial) port of the SRAM controller.
- Parses a byte protocol from the UART receiver and issues single-byte SRAM reads/writes with a 20-bit address.
- Streams read data back through the UART transmitter.
- Lets a host PC load and dump the emulated SPI EEPROM image while the SPI emulator keeps running on the other SRAM port.

---
 rtl/ser_mem_cmd_pkg.sv | 31 +++
 rtl/ser_mem_rxbuf.sv | 52 +++++
 rtl/ser_mem_cmd.sv | 212 +++++++++++++++++++++
 tb/tb_ser_mem_cmd.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_mem_cmd_pkg.sv
// Shared definitions for ser_mem_cmd: protocol command codes, ack byte and FSM state encoding.
// The ACK state is only defined when SER_MEM_CMD_ACK_EN is set.
package ser_mem_cmd_pkg;

    typedef logic [3:0] state_t;

    localparam logic [7:0] CMD_SETADDR = 8'h01;
    localparam logic [7:0] CMD_WRITE   = 8'h02;
    localparam logic [7:0] CMD_READ    = 8'h03;
    localparam logic [7:0] ACK_BYTE    = 8'hA5;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_A2    = 4'd1;
    localparam logic [3:0] ST_A1    = 4'd2;
    localparam logic [3:0] ST_A0    = 4'd3;
    localparam logic [3:0] ST_WLEN  = 4'd4;
    localparam logic [3:0] ST_WDATA = 4'd5;
    localparam logic [3:0] ST_WMEM  = 4'd6;
    localparam logic [3:0] ST_RLEN  = 4'd7;
    localparam logic [3:0] ST_RMEM  = 4'd8;
    localparam logic [3:0] ST_RTX   = 4'd9;
`ifdef SER_MEM_CMD_ACK_EN
    localparam logic [3:0] ST_ACK   = 4'd10;
`endif

    // While a READ is streaming out, incoming bytes carry no meaning and are thrown away.
    function automatic logic is_read_state(input state_t st);
        return (st == ST_RMEM) || (st == ST_RTX);
    endfunction

endpackage

// File: rtl/ser_mem_rxbuf.sv
// One-byte receive holding register with full flag and sticky overrun detection.
// A pop and a new byte in the same cycle keep the register full with the new byte.
module ser_mem_rxbuf (
    input  logic       mclk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_strobe,
    input  logic       discard,
    input  logic       pop,
    output logic       full,
    output logic [7:0] data,
    output logic       overrun
);

    logic       full_d, full_q;
    logic [7:0] data_d, data_q;
    logic       overrun_d, overrun_q;

    always_comb begin
        full_d    = full_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        if (pop) begin
            full_d = 1'b0;
        end
        if (rx_strobe && !discard) begin
            if (full_q && !pop) begin
                overrun_d = 1'b1;
            end else begin
                full_d = 1'b1;
                data_d = rx_data;
            end
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            full_q    <= 1'b0;
            data_q    <= 8'h00;
            overrun_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign full    = full_q;
    assign data    = data_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/ser_mem_cmd.sv
// ser_mem_cmd: UART byte-protocol engine issuing single-byte SRAM reads/writes on the serial port.
// Define SER_MEM_CMD_ACK_EN to transmit ACK_BYTE after every completed SETADDR or WRITE.
module ser_mem_cmd
    import ser_mem_cmd_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int LEN_W  = 8
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_strobe,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_strobe,
    output logic              mem_begin_wr,
    output logic              mem_begin_rd,
    input  logic              mem_finish,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data_wr,
    input  logic [7:0]        mem_data_rd,
    output logic              busy,
    output logic              overrun
);

`ifdef SER_MEM_CMD_ACK_EN
    localparam state_t ST_DONE = ST_ACK;
`else
    localparam state_t ST_DONE = ST_IDLE;
`endif

    state_t            state_d, state_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [15:0]       addr_hi_d, addr_hi_q;
    logic [LEN_W-1:0]  cnt_d, cnt_q;
    logic [7:0]        wdata_d, wdata_q;
    logic [7:0]        txd_d, txd_q;
    logic              begin_wr_d, begin_wr_q;
    logic              begin_rd_d, begin_rd_q;
    logic              tx_gap_d, tx_gap_q;

    logic              rx_full;
    logic [7:0]        rx_byte;
    logic              rx_pop;
    logic              tx_fire;

    ser_mem_rxbuf u_rxbuf (
        .mclk     (mclk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_strobe(rx_strobe),
        .discard  (is_read_state(state_q)),
        .pop      (rx_pop),
        .full     (rx_full),
        .data     (rx_byte),
        .overrun  (overrun)
    );

    // The cycle right after a strobe never strobes again, whatever tx_ready says.
`ifdef SER_MEM_CMD_ACK_EN
    assign tx_fire = ((state_q == ST_RTX) || (state_q == ST_ACK)) && tx_ready && !tx_gap_q;
`else
    assign tx_fire = (state_q == ST_RTX) && tx_ready && !tx_gap_q;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        addr_hi_d = addr_hi_q;
        cnt_d     = cnt_q;
        wdata_d   = wdata_q;
        txd_d     = txd_q;
        rx_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_full) begin
                    rx_pop = 1'b1;
                    case (rx_byte)
                        CMD_SETADDR: state_d = ST_A2;
                        CMD_WRITE:   state_d = ST_WLEN;
                        CMD_READ:    state_d = ST_RLEN;
                        default:     state_d = ST_IDLE;
                    endcase
                end
            end
            ST_A2: begin
                if (rx_full) begin
                    rx_pop          = 1'b1;
                    addr_hi_d[15:8] = rx_byte;
                    state_d         = ST_A1;
                end
            end
            ST_A1: begin
                if (rx_full) begin
                    rx_pop         = 1'b1;
                    addr_hi_d[7:0] = rx_byte;
                    state_d        = ST_A0;
                end
            end
            ST_A0: begin
                if (rx_full) begin
                    rx_pop  = 1'b1;
                    addr_d  = ADDR_W'({addr_hi_q, rx_byte});
                    state_d = ST_DONE;
                end
            end
            // cnt holds "bytes left after the current one", so a length of 0 wraps to the full range.
            ST_WLEN: begin
                if (rx_full) begin
                    rx_pop  = 1'b1;
                    cnt_d   = LEN_W'(rx_byte) - LEN_W'(1);
                    state_d = ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (rx_full) begin
                    rx_pop  = 1'b1;
                    wdata_d = rx_byte;
                    state_d = ST_WMEM;
                end
            end
            ST_WMEM: begin
                if (mem_finish) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q - LEN_W'(1);
                        state_d = ST_WDATA;
                    end
                end
            end
            ST_RLEN: begin
                if (rx_full) begin
                    rx_pop  = 1'b1;
                    cnt_d   = LEN_W'(rx_byte) - LEN_W'(1);
                    state_d = ST_RMEM;
                end
            end
            ST_RMEM: begin
                if (mem_finish) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    txd_d   = mem_data_rd;
                    state_d = ST_RTX;
                end
            end
            ST_RTX: begin
                if (tx_fire) begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q - LEN_W'(1);
                        state_d = ST_RMEM;
                    end
                end
            end
`ifdef SER_MEM_CMD_ACK_EN
            ST_ACK: begin
                if (tx_fire) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

`ifdef SER_MEM_CMD_ACK_EN
        if ((state_d == ST_ACK) && (state_q != ST_ACK)) begin
            txd_d = ACK_BYTE;
        end
`endif
    end

    // Requests are single-cycle pulses raised on entry to the memory-wait states.
    assign begin_wr_d = (state_d == ST_WMEM) && (state_q != ST_WMEM);
    assign begin_rd_d = (state_d == ST_RMEM) && (state_q != ST_RMEM);
    assign tx_gap_d   = tx_fire;

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            addr_hi_q  <= '0;
            cnt_q      <= '0;
            wdata_q    <= 8'h00;
            txd_q      <= 8'h00;
            begin_wr_q <= 1'b0;
            begin_rd_q <= 1'b0;
            tx_gap_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            addr_hi_q  <= addr_hi_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            txd_q      <= txd_d;
            begin_wr_q <= begin_wr_d;
            begin_rd_q <= begin_rd_d;
            tx_gap_q   <= tx_gap_d;
        end
    end

    assign tx_data      = txd_q;
    assign tx_strobe    = tx_fire;
    assign mem_begin_wr = begin_wr_q;
    assign mem_begin_rd = begin_rd_q;
    assign mem_addr     = addr_q;
    assign mem_data_wr  = wdata_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ser_mem_cmd.sv
// Self-checking bench for ser_mem_cmd: command table, corner-case sequences and random commands
// compared against a command-level protocol model; builds with or without SER_MEM_CMD_ACK_EN.
`timescale 1ns/1ps
module tb_ser_mem_cmd;

`ifdef SER_MEM_CMD_ACK_EN
    localparam int ACKN = 1;
`else
    localparam int ACKN = 0;
`endif

    logic        mclk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_strobe = 1'b0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_strobe;
    logic        mem_begin_wr;
    logic        mem_begin_rd;
    logic        mem_finish;
    logic [19:0] mem_addr;
    logic [7:0]  mem_data_wr;
    logic [7:0]  mem_data_rd;
    logic        busy;
    logic        overrun;

    always #5 mclk = ~mclk;

    ser_mem_cmd #(.ADDR_W(20), .LEN_W(8)) dut (
        .mclk        (mclk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_strobe   (rx_strobe),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_strobe   (tx_strobe),
        .mem_begin_wr(mem_begin_wr),
        .mem_begin_rd(mem_begin_rd),
        .mem_finish  (mem_finish),
        .mem_addr    (mem_addr),
        .mem_data_wr (mem_data_wr),
        .mem_data_rd (mem_data_rd),
        .busy        (busy),
        .overrun     (overrun)
    );

    typedef struct packed {
        logic [19:0] addr;
        logic [7:0]  data;
    } wr_t;

    // Unwritten SRAM locations read back as a fixed function of the address.
    function automatic logic [7:0] dflt(input logic [19:0] a);
        return 8'hC3 ^ (a[7:0] & 8'h99);
    endfunction

    // ---------------- SRAM responder ----------------
    logic       sram_hold = 1'b0;
    logic [7:0] sram [int];

    initial begin
        mem_finish  = 1'b0;
        mem_data_rd = 8'h00;
        forever begin
            @(negedge mclk);
            if (!reset && (mem_begin_wr || mem_begin_rd)) begin
                logic        w;
                logic [19:0] a;
                logic [7:0]  d;
                int          lat;
                w   = mem_begin_wr;
                a   = mem_addr;
                d   = mem_data_wr;
                lat = int'($urandom_range(0, 3));
                repeat (lat) @(posedge mclk);
                while (sram_hold) @(posedge mclk);
                @(posedge mclk);
                #1;
                mem_finish = 1'b1;
                if (w) sram[int'(a)] = d;
                else mem_data_rd = sram.exists(int'(a)) ? sram[int'(a)] : dflt(a);
                @(posedge mclk);
                #1;
                mem_finish  = 1'b0;
                mem_data_rd = 8'($urandom);
            end
        end
    end

    // ---------------- Output monitor ----------------
    wr_t         wr_log [$];
    logic [19:0] rd_log [$];
    logic [7:0]  tx_log [$];
    int          mon_err = 0;
    logic        pend = 1'b0, pend_wr = 1'b0;
    logic [19:0] pend_addr = '0;
    logic [7:0]  pend_data = '0;
    logic        prev_bw = 1'b0, prev_br = 1'b0, prev_tx = 1'b0;

    always @(negedge mclk) begin
        if (reset) begin
            pend    = 1'b0;
            prev_bw = 1'b0;
            prev_br = 1'b0;
            prev_tx = 1'b0;
        end else begin
            if (pend && (mem_addr !== pend_addr || (pend_wr && mem_data_wr !== pend_data)))
                mon_err++;
            if (pend && mem_finish) pend = 1'b0;
            if (mem_begin_wr || mem_begin_rd) begin
                if (pend || (mem_begin_wr && mem_begin_rd)) mon_err++;
                pend      = 1'b1;
                pend_wr   = mem_begin_wr;
                pend_addr = mem_addr;
                pend_data = mem_data_wr;
            end
            if ((mem_begin_wr && prev_bw) || (mem_begin_rd && prev_br)) mon_err++;
            if (mem_begin_wr) wr_log.push_back({mem_addr, mem_data_wr});
            if (mem_begin_rd) rd_log.push_back(mem_addr);
            if (tx_strobe) begin
                tx_log.push_back(tx_data);
                if (prev_tx) mon_err++;
            end
            prev_bw = mem_begin_wr;
            prev_br = mem_begin_rd;
            prev_tx = tx_strobe;
        end
    end

    // ---------------- Command-level reference model ----------------
    logic [7:0]  mm [int];
    logic [19:0] m_addr = '0;
    wr_t         e_wr [$];
    logic [19:0] e_rd [$];
    logic [7:0]  e_tx [$];

    task automatic model_stream(input logic [7:0] q [$], input bit complete);
        int idx, n, full;
        idx = 0;
        while (idx < q.size()) begin
            case (q[idx])
                8'h01: begin
                    full   = (int'(q[idx+1]) << 16) + (int'(q[idx+2]) << 8) + int'(q[idx+3]);
                    m_addr = 20'(full % (1 << 20));
                    if (complete && ACKN != 0) e_tx.push_back(8'hA5);
                    idx += 4;
                end
                8'h02: begin
                    n = (q[idx+1] == 8'h00) ? 256 : int'(q[idx+1]);
                    for (int i = 0; i < n && idx + 2 + i < q.size(); i++) begin
                        e_wr.push_back({m_addr, q[idx+2+i]});
                        mm[int'(m_addr)] = q[idx+2+i];
                        m_addr = 20'((int'(m_addr) + 1) % (1 << 20));
                    end
                    if (complete && ACKN != 0) e_tx.push_back(8'hA5);
                    idx += 2 + n;
                end
                8'h03: begin
                    n = (q[idx+1] == 8'h00) ? 256 : int'(q[idx+1]);
                    for (int i = 0; i < n; i++) begin
                        e_rd.push_back(m_addr);
                        e_tx.push_back(mm.exists(int'(m_addr)) ? mm[int'(m_addr)] : dflt(m_addr));
                        m_addr = 20'((int'(m_addr) + 1) % (1 << 20));
                    end
                    idx += 2;
                end
                default: idx += 1;
            endcase
        end
    endtask

    // ---------------- Checking helpers ----------------
    int checks = 0, passed = 0;
    int wr_cur = 0, rd_cur = 0, tx_cur = 0, ewr_cur = 0, erd_cur = 0, etx_cur = 0;
    bit tx_rand = 1'b1, tx_fixed = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic sync_logs(input string tag);
        int na, ne;
        na = wr_log.size() - wr_cur; ne = e_wr.size() - ewr_cur;
        check({tag, " wr count"}, 32'(na), 32'(ne));
        for (int i = 0; i < na && i < ne; i++)
            check({tag, " wr req"}, 32'(wr_log[wr_cur+i]), 32'(e_wr[ewr_cur+i]));
        na = rd_log.size() - rd_cur; ne = e_rd.size() - erd_cur;
        check({tag, " rd count"}, 32'(na), 32'(ne));
        for (int i = 0; i < na && i < ne; i++)
            check({tag, " rd addr"}, 32'(rd_log[rd_cur+i]), 32'(e_rd[erd_cur+i]));
        na = tx_log.size() - tx_cur; ne = e_tx.size() - etx_cur;
        check({tag, " tx count"}, 32'(na), 32'(ne));
        for (int i = 0; i < na && i < ne; i++)
            check({tag, " tx byte"}, 32'(tx_log[tx_cur+i]), 32'(e_tx[etx_cur+i]));
        wr_cur = wr_log.size(); rd_cur = rd_log.size(); tx_cur = tx_log.size();
        ewr_cur = e_wr.size(); erd_cur = e_rd.size(); etx_cur = e_tx.size();
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
        tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : tx_fixed;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data   = b;
        rx_strobe = 1'b1;
        tick();
        rx_strobe = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check({tag, " idle"}, 32'(busy), 32'(0));
    endtask

    task automatic do_reset(input bit chk);
        tick();
        reset     = 1'b1;
        rx_strobe = 1'b0;
        sram_hold = 1'b0;
        #1;
        if (chk) begin
            check("rst busy", 32'(busy), 32'(0));
            check("rst overrun", 32'(overrun), 32'(0));
            check("rst tx_strobe", 32'(tx_strobe), 32'(0));
            check("rst tx_data", 32'(tx_data), 32'(0));
            check("rst begins", 32'({mem_begin_wr, mem_begin_rd}), 32'(0));
            check("rst mem_addr", 32'(mem_addr), 32'(0));
            check("rst mem_data_wr", 32'(mem_data_wr), 32'(0));
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        m_addr = '0;
    endtask

    // ---------------- Command table ----------------
    typedef struct {
        logic [79:0] bytes;
        int          n;
        int          n_wr;
        int          n_rd;
        int          n_tx;
        logic [19:0] addr_end;
    } vec_t;

    vec_t        vt [7];
    logic [7:0]  cq [$];
    int          lat_seen;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{80'h0100_1234_0202_AABB_0000, 8, 2, 0, 2*ACKN, 20'h01236};
        vt[1] = '{80'h010F_FFFF_0302_0000_0000, 6, 0, 2, 2+ACKN, 20'h00001};
        vt[2] = '{80'h7F00_0000_0000_0000_0000, 1, 0, 0, 0,      20'h00000};
        vt[3] = '{80'h0100_0000_0000_0000_0000, 4, 0, 0, ACKN,   20'h00000};
        vt[4] = '{80'h01FF_ABCD_0000_0000_0000, 4, 0, 0, ACKN,   20'hFABCD};
        vt[5] = '{80'h0201_7700_0000_0000_0000, 3, 1, 0, ACKN,   20'h00001};
        vt[6] = '{80'h010F_FFFE_0203_1020_3000, 9, 3, 0, 2*ACKN, 20'h00001};

        tx_rand = 1'b1;
        for (int v = 0; v < 7; v++) begin
            do_reset(v == 0);
            sync_logs("pre");
            cq = {};
            for (int i = 0; i < vt[v].n; i++) begin
                cq.push_back(vt[v].bytes[79-8*i -: 8]);
                send_byte(vt[v].bytes[79-8*i -: 8], 8);
            end
            wait_idle($sformatf("vec%0d", v), 4000);
            check($sformatf("vec%0d n_wr", v), 32'(wr_log.size() - wr_cur), 32'(vt[v].n_wr));
            check($sformatf("vec%0d n_rd", v), 32'(rd_log.size() - rd_cur), 32'(vt[v].n_rd));
            check($sformatf("vec%0d n_tx", v), 32'(tx_log.size() - tx_cur), 32'(vt[v].n_tx));
            check($sformatf("vec%0d addr", v), 32'(mem_addr), 32'(vt[v].addr_end));
            check($sformatf("vec%0d overrun", v), 32'(overrun), 32'(0));
            model_stream(cq, 1'b1);
            sync_logs($sformatf("vec%0d", v));
        end

        // Reset in the middle of a WRITE, then read address 0.
        do_reset(0);
        cq = {8'h02, 8'h04, 8'h11};
        foreach (cq[i]) send_byte(cq[i], 8);
        check("midwr busy", 32'(busy), 32'(1));
        do_reset(1);
        model_stream(cq, 1'b0);
        m_addr = '0;
        sync_logs("midwr");
        cq = {8'h03, 8'h01};
        foreach (cq[i]) send_byte(cq[i], 8);
        wait_idle("midwr rd", 2000);
        model_stream(cq, 1'b1);
        sync_logs("midwr rd");

        // Write request latency from the data byte's strobe.
        do_reset(0);
        send_byte(8'h02, 8);
        send_byte(8'h01, 8);
        rx_data   = 8'h3C;
        rx_strobe = 1'b1;
        lat_seen  = -1;
        for (int i = 0; i < 4; i++) begin
            @(negedge mclk);
            if (mem_begin_wr && lat_seen < 0) lat_seen = i;
            tick();
            rx_strobe = 1'b0;
        end
        check("wr latency", 32'(lat_seen >= 0 && lat_seen <= 2), 32'(1));
        wait_idle("lat", 2000);
        cq = {8'h02, 8'h01, 8'h3C};
        model_stream(cq, 1'b1);
        sync_logs("lat");

        // Two bytes arrive while a write is held pending.
        do_reset(0);
        sram_hold = 1'b1;
        send_byte(8'h02, 8);
        send_byte(8'h02, 8);
        send_byte(8'hAA, 4);
        send_byte(8'h55, 1);
        send_byte(8'h66, 2);
        check("ovr set", 32'(overrun), 32'(1));
        check("ovr busy", 32'(busy), 32'(1));
        sram_hold = 1'b0;
        repeat (20) tick();
        wait_idle("ovr", 2000);
        check("ovr sticky", 32'(overrun), 32'(1));
        cq = {8'h02, 8'h02, 8'hAA, 8'h55};
        model_stream(cq, 1'b1);
        sync_logs("ovr");
        send_byte(8'h7F, 8);
        check("ovr sticky2", 32'(overrun), 32'(1));
        check("unknown cmd busy", 32'(busy), 32'(0));
        do_reset(1);

        // Bytes received during a READ are discarded without overrun.
        tx_rand  = 1'b0;
        tx_fixed = 1'b0;
        send_byte(8'h03, 8);
        send_byte(8'h02, 8);
        send_byte(8'h01, 2);
        send_byte(8'h01, 2);
        check("rdisc busy", 32'(busy), 32'(1));
        check("rdisc overrun", 32'(overrun), 32'(0));
        tx_fixed = 1'b1;
        wait_idle("rdisc", 2000);
        repeat (6) tick();
        check("rdisc stays idle", 32'(busy), 32'(0));
        cq = {8'h03, 8'h02};
        model_stream(cq, 1'b1);
        sync_logs("rdisc");

        // Length 0 read: 256 bytes.
        tx_rand = 1'b1;
        do_reset(0);
        cq = {8'h01, 8'h00, 8'h00, 8'h80, 8'h03, 8'h00};
        foreach (cq[i]) send_byte(cq[i], 8);
        wait_idle("rd256", 20000);
        check("rd256 n_rd", 32'(rd_log.size() - rd_cur), 32'(256));
        check("rd256 n_tx", 32'(tx_log.size() - tx_cur), 32'(256 + ACKN));
        check("rd256 addr", 32'(mem_addr), 32'(20'h00180));
        model_stream(cq, 1'b1);
        sync_logs("rd256");

        // Randomized command stream.
        do_reset(0);
        for (int k = 0; k < 30; k++) begin
            int kind, n;
            kind = int'($urandom_range(0, 3));
            cq = {};
            case (kind)
                0: begin
                    cq.push_back(8'h01);
                    cq.push_back(8'($urandom));
                    cq.push_back((k % 3 == 0) ? 8'hFF : 8'($urandom));
                    cq.push_back((k % 3 == 0) ? 8'hFE : 8'($urandom));
                end
                1: begin
                    n = int'($urandom_range(1, 5));
                    cq.push_back(8'h02);
                    cq.push_back(8'(n));
                    for (int i = 0; i < n; i++) cq.push_back(8'($urandom));
                end
                2: begin
                    cq.push_back(8'h03);
                    cq.push_back(8'($urandom_range(1, 5)));
                end
                default: cq.push_back(8'($urandom_range(4, 255)));
            endcase
            foreach (cq[i]) send_byte(cq[i], 8);
            wait_idle("rand", 2000);
            model_stream(cq, 1'b1);
            check("rand addr", 32'(mem_addr), 32'(m_addr));
        end
        sync_logs("rand");
        check("rand overrun", 32'(overrun), 32'(0));
        check("handshake protocol", 32'(mon_err), 32'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
